// File: rtl/nested_loop_sequencer.sv
// Two-level (outer m / inner n) loop sequencer with run-time bounds,
// start/busy/done handshake, abort, and an optional idle gap between inner runs.
module nested_loop_sequencer #(
  parameter int N_W = 4,
  parameter int M_W = 4,
  parameter int GAP = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           abort,
  input  logic           enable,
  input  logic [N_W-1:0] n_cfg,
  input  logic [M_W-1:0] m_cfg,
  output logic           out,
  output logic [N_W-1:0] n_idx,
  output logic [M_W-1:0] m_idx,
  output logic           busy,
  output logic           done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t         state, state_nx;
  logic [N_W-1:0] n_lat, n_lat_nx, n_idx_nx, n_last;
  logic [M_W-1:0] m_lat, m_lat_nx, m_idx_nx, m_last;
  logic [3:0]     gap_cnt, gap_cnt_nx;

  // Bounds are never zero outside IDLE, so cfg-1 cannot wrap while in use.
  assign n_last = n_lat - N_W'(1);
  assign m_last = m_lat - M_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      n_lat   <= '0;
      m_lat   <= '0;
      n_idx   <= '0;
      m_idx   <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_nx;
      n_lat   <= n_lat_nx;
      m_lat   <= m_lat_nx;
      n_idx   <= n_idx_nx;
      m_idx   <= m_idx_nx;
      gap_cnt <= gap_cnt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    n_lat_nx   = n_lat;
    m_lat_nx   = m_lat;
    n_idx_nx   = n_idx;
    m_idx_nx   = m_idx;
    gap_cnt_nx = gap_cnt;

    case (state)
      S_IDLE: begin
        if (start) begin
          n_lat_nx = n_cfg;
          m_lat_nx = m_cfg;
          n_idx_nx = '0;
          m_idx_nx = '0;
          state_nx = (n_cfg == '0 || m_cfg == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (enable) begin
          if (n_idx == n_last) begin
            n_idx_nx = '0;
            if (m_idx == m_last) begin
              state_nx = S_DONE;
            end else begin
              m_idx_nx = m_idx + M_W'(1);
              if (GAP > 0) begin
                gap_cnt_nx = GAP_LOAD;
                state_nx   = S_GAP;
              end
            end
          end else begin
            n_idx_nx = n_idx + N_W'(1);
          end
        end
      end
      S_GAP: begin
        if (enable) begin
          if (gap_cnt == '0) state_nx = S_RUN;
          else               gap_cnt_nx = gap_cnt - 4'd1;
        end
      end
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase

    if (abort) begin
      state_nx   = S_IDLE;
      n_idx_nx   = '0;
      m_idx_nx   = '0;
      gap_cnt_nx = '0;
    end
  end

  assign out  = (state == S_RUN) & enable;
  assign busy = (state == S_RUN) | (state == S_GAP);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_nested_loop_sequencer.sv
// Directed bench for nested_loop_sequencer: a GAP=1 instance for the main
// scenarios and a GAP=0 instance for the full 15x15 run.
module tb_nested_loop_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, abort, enable;
  logic [3:0] n_cfg, m_cfg;
  logic       out, busy, done;
  logic [3:0] n_idx, m_idx;
  logic       out0, busy0, done0;
  logic [3:0] n_idx0, m_idx0;

  int tests = 0;
  int fails = 0;

  logic [15:0] obs_out, obs_busy, obs_done;
  int          obs_n[16];
  int          obs_m[16];

  always #5 clk = ~clk;

  nested_loop_sequencer #(.N_W(4), .M_W(4), .GAP(1)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .enable(enable),
    .n_cfg(n_cfg), .m_cfg(m_cfg), .out(out), .n_idx(n_idx), .m_idx(m_idx),
    .busy(busy), .done(done)
  );

  nested_loop_sequencer #(.N_W(4), .M_W(4), .GAP(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .enable(enable),
    .n_cfg(n_cfg), .m_cfg(m_cfg), .out(out0), .n_idx(n_idx0), .m_idx(m_idx0),
    .busy(busy0), .done(done0)
  );

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Cycle 0 carries the start pulse; each cycle is sampled 2ns after its edge.
  // Bounds are changed in cycle 1 and a second start may be issued to show both are ignored.
  task automatic observe(input int ncyc, input logic [15:0] en_off,
                         input int abort_cyc, input int restart_cyc);
    obs_out = '0; obs_busy = '0; obs_done = '0;
    for (int c = 0; c < ncyc; c++) begin
      start  = (c == 0) || (c == restart_cyc);
      enable = !en_off[c];
      abort  = (c == abort_cyc);
      if (c == 1) begin
        n_cfg = 4'd7;
        m_cfg = 4'd9;
      end
      #1;
      obs_out[c]  = out;
      obs_busy[c] = busy;
      obs_done[c] = done;
      obs_n[c]    = int'(n_idx);
      obs_m[c]    = int'(m_idx);
      @(posedge clk); #1;
    end
    start = 1'b0; abort = 1'b0; enable = 1'b1;
  endtask

  task automatic check_basic(input string tag);
    check({tag, "_out"},  int'(obs_out),  'h0EE);
    check({tag, "_busy"}, int'(obs_busy), 'h0FE);
    check({tag, "_done"}, int'(obs_done), 'h100);
  endtask

  initial begin
    int cyc, strobes, idx_err, holes, done_at;
    reset = 1'b1; start = 1'b0; abort = 1'b0; enable = 1'b1;
    n_cfg = '0; m_cfg = '0;
    #1;
    check("rst_out", int'(out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_idx", int'({n_idx, m_idx}), 0);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Basic 3x2 with one gap cycle
    n_cfg = 4'd3; m_cfg = 4'd2;
    observe(11, 16'h0000, -1, -1);
    check_basic("s1");
    for (int c = 1; c <= 7; c++) begin
      if (c != 4) begin
        check($sformatf("s1_n%0d", c), obs_n[c], (c < 4) ? c - 1 : c - 5);
        check($sformatf("s1_m%0d", c), obs_m[c], (c < 4) ? 0 : 1);
      end
    end

    // enable low in cycles 2-3 freezes progress
    n_cfg = 4'd3; m_cfg = 4'd2;
    observe(12, 16'h000C, -1, -1);
    check("s2_out", int'(obs_out), 'h3B2);
    check("s2_busy", int'(obs_busy), 'h3FE);
    check("s2_done", int'(obs_done), 'h400);
    check("s2_n2", obs_n[2], 1);
    check("s2_n3", obs_n[3], 1);
    check("s2_m8", obs_m[8], 1);

    // Zero-work sequence
    n_cfg = 4'd0; m_cfg = 4'd5;
    observe(4, 16'h0000, -1, -1);
    check("s3_out", int'(obs_out), 0);
    check("s3_busy", int'(obs_busy), 0);
    check("s3_done", int'(obs_done), 'h2);

    // Abort during the gap cycle, then a clean rerun
    n_cfg = 4'd3; m_cfg = 4'd2;
    observe(10, 16'h0000, 4, -1);
    check("s5_out", int'(obs_out), 'h0E);
    check("s5_busy", int'(obs_busy), 'h1E);
    check("s5_done", int'(obs_done), 0);
    check("s5_idx", obs_n[5] + 16 * obs_m[5], 0);
    n_cfg = 4'd3; m_cfg = 4'd2;
    observe(11, 16'h0000, -1, -1);
    check_basic("s5r");

    // Async reset mid-RUN, then a run with an ignored second start
    n_cfg = 4'd3; m_cfg = 4'd2;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #3;
    check("s6_pre_out", int'(out), 1);
    reset = 1'b1;
    #1;
    check("s6_rst_out", int'(out), 0);
    check("s6_rst_busy", int'(busy), 0);
    check("s6_rst_idx", int'({n_idx, m_idx}), 0);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    n_cfg = 4'd3; m_cfg = 4'd2;
    observe(11, 16'h0000, -1, 2);
    check_basic("s6");

    // Full 15x15 on the GAP=0 instance
    n_cfg = 4'd15; m_cfg = 4'd15;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 1; strobes = 0; idx_err = 0; holes = 0; done_at = -1;
    while (cyc < 260 && done_at < 0) begin
      #1;
      if (out0) begin
        if (int'(n_idx0) != strobes % 15 || int'(m_idx0) != strobes / 15) idx_err++;
        strobes++;
      end else if (!done0) begin
        holes++;
      end
      if (done0) done_at = cyc;
      @(posedge clk); #1;
      cyc++;
    end
    check("s4_strobes", strobes, 225);
    check("s4_idx_err", idx_err, 0);
    check("s4_holes", holes, 0);
    check("s4_done_at", done_at, 226);
    #1;
    check("s4_done_once", int'(done0), 0);
    check("s4_idle", int'(busy0), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
